// File: rtl/gp_register_file_if.sv
// Bus bundle between the control side (decode/ALU/memory) and gp_register_file.
// The register file takes the slave view; whoever drives writes, reads and loads takes master.
interface gp_register_file_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 4
);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [DATA_W-1:0]   rd_data_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [DATA_W-1:0]   rd_data_b;
    logic                acc_alu_we;
    logic [DATA_W-1:0]   acc_alu_data;
    logic                acc_mem_we;
    logic [DATA_W-1:0]   acc_mem_data;
    logic [DATA_W-1:0]   acc_out;
    logic                acc_zero;
    logic                acc_neg;
    logic                rsv_en;
    logic [ADDR_W-1:0]   rsv_addr;
    logic [NUM_REGS-1:0] busy;
    logic                acc_conflict;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
               acc_alu_we, acc_alu_data, acc_mem_we, acc_mem_data,
               rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, acc_out, acc_zero, acc_neg, busy, acc_conflict
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
               acc_alu_we, acc_alu_data, acc_mem_we, acc_mem_data,
               rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, acc_out, acc_zero, acc_neg, busy, acc_conflict
    );
endinterface

// File: rtl/gp_register_file.sv
// General-purpose register file with two combinational read ports, one write port,
// an accumulator fed by ALU or memory, and a per-register load-pending scoreboard.
module gp_register_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1
) (
    input logic clk,
    input logic rst,
    gp_register_file_if.slave bus
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   acc;
    logic [NUM_REGS-1:0] busy_q;
    logic                conflict_q;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;

    // Address matching by loop means out-of-range addresses simply hit nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            acc        <= '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
                    regs[i] <= bus.wr_data;
                end
                // A new reservation outranks the write that would retire it.
                if (bus.rsv_en && bus.rsv_addr == ADDR_W'(i)) begin
                    busy_q[i] <= 1'b1;
                end else if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) begin
                    busy_q[i] <= 1'b0;
                end
            end
            if (bus.acc_alu_we) begin
                acc <= bus.acc_alu_data;
            end else if (bus.acc_mem_we) begin
                acc <= bus.acc_mem_data;
            end
            conflict_q <= bus.acc_alu_we & bus.acc_mem_we;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr_a == ADDR_W'(i)) begin
                rd_a = (BYPASS != 0 && bus.wr_en && bus.wr_addr == ADDR_W'(i))
                       ? bus.wr_data : regs[i];
            end
            if (bus.rd_addr_b == ADDR_W'(i)) begin
                rd_b = (BYPASS != 0 && bus.wr_en && bus.wr_addr == ADDR_W'(i))
                       ? bus.wr_data : regs[i];
            end
        end
    end

    assign bus.rd_data_a    = rd_a;
    assign bus.rd_data_b    = rd_b;
    assign bus.acc_out      = acc;
    assign bus.acc_zero     = (acc == '0);
    assign bus.acc_neg      = acc[DATA_W-1];
    assign bus.busy         = busy_q;
    assign bus.acc_conflict = conflict_q;

endmodule
